// File: rtl/wait_cycles_caller_pkg.sv
`default_nettype none
//==============================================================================
// wait_cycles_caller_pkg : shared argument width and FSM state encoding
// Rev 1.0
//==============================================================================
package wait_cycles_caller_pkg;

    localparam int unsigned ARG_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/wait_cycles_caller_if.sv
`default_nettype none
//==============================================================================
// wait_cycles_caller_if : producer command port, responder request port, status
// Rev 1.0
//==============================================================================
interface wait_cycles_caller_if;
    import wait_cycles_caller_pkg::*;

    logic             cmd_valid;
    logic [ARG_W-1:0] cmd_cycles;
    logic             cmd_ready;
    logic             req_valid;
    logic [ARG_W-1:0] req_0;
    logic             req_ready;
    logic             busy;
    logic [15:0]      done_count;
    logic             timeout_err;

    // master = the caller, slave = producer/responder/observer side
    modport master (
        input  cmd_valid, cmd_cycles, req_ready,
        output cmd_ready, req_valid, req_0, busy, done_count, timeout_err
    );

    modport slave (
        output cmd_valid, cmd_cycles, req_ready,
        input  cmd_ready, req_valid, req_0, busy, done_count, timeout_err
    );

endinterface
`default_nettype wire

// File: rtl/wait_cycles_caller_cmd_fifo.sv
`default_nettype none
//==============================================================================
// cmd_fifo : single-clock DEPTH-entry FIFO; push ignored when full, pop when empty
// Rev 1.0
//==============================================================================
module cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] data_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned      PTR_W  = $clog2(DEPTH);
    localparam logic [PTR_W:0]   C_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (count_q == C_FULL);
    assign empty_o = (count_q == '0);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is qualified by the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/wait_cycles_caller.sv
`default_nettype none
//==============================================================================
// wait_cycles_caller : queues delay commands and issues them one at a time
// Rev 1.0
//==============================================================================
module wait_cycles_caller
    import wait_cycles_caller_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    wait_cycles_caller_if.master bus
);

    localparam logic [31:0] C_WD_LAST = 32'(TIMEOUT) - 32'd1;

    state_e           state_q, state_d;
    logic             req_valid_q, req_valid_d;
    logic [ARG_W-1:0] req_0_q, req_0_d;
    logic [15:0]      done_count_q, done_count_d;
    logic             timeout_err_q, timeout_err_d;
    logic [31:0]      wdog_q, wdog_d;

    logic             w_pop;
    logic [ARG_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ARG_W)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.cmd_valid),
        .data_i  (bus.cmd_cycles),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            req_valid_q   <= 1'b0;
            req_0_q       <= '0;
            done_count_q  <= '0;
            timeout_err_q <= 1'b0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            req_valid_q   <= req_valid_d;
            req_0_q       <= req_0_d;
            done_count_q  <= done_count_d;
            timeout_err_q <= timeout_err_d;
            wdog_q        <= wdog_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        req_valid_d   = req_valid_q;
        req_0_d       = req_0_q;
        done_count_d  = done_count_q;
        timeout_err_d = timeout_err_q;
        wdog_d        = wdog_q;
        w_pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    req_0_d     = w_head;
                    req_valid_d = 1'b1;
                    wdog_d      = '0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Completion takes priority over a coincident watchdog expiry.
                if (bus.req_ready) begin
                    req_valid_d  = 1'b0;
                    done_count_d = done_count_q + 16'd1;
                    state_d      = ST_GAP;
                end else if ((TIMEOUT != 0) && (wdog_q == C_WD_LAST)) begin
                    req_valid_d   = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = ST_HALT;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            // One idle cycle lets the responder drop back before the next request.
            ST_GAP:  state_d = ST_IDLE;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.cmd_ready   = !w_full;
    assign bus.req_valid   = req_valid_q;
    assign bus.req_0       = req_0_q;
    assign bus.busy        = !w_empty || (state_q != ST_IDLE);
    assign bus.done_count  = done_count_q;
    assign bus.timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_wait_cycles_caller.sv
`default_nettype none
//==============================================================================
// tb_wait_cycles_caller : directed checks of wait_cycles_caller with a cycle-wait responder
// Rev 1.0
//==============================================================================
module tb_wait_cycles_caller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wait_cycles_caller_if b0 ();
    wait_cycles_caller_if b1 ();

    wait_cycles_caller #(.DEPTH(4), .TIMEOUT(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    wait_cycles_caller #(.DEPTH(4), .TIMEOUT(8)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    int total = 0;
    int bad   = 0;

    // Cycle-wait responder on b0: completion pulse in the (arg+3)-th cycle of req_valid.
    logic resp_en      = 1'b1;
    logic manual_ready = 1'b0;
    int   rcnt         = 0;
    always @(negedge clk) begin
        if (rst || !b0.req_valid || !resp_en) begin
            rcnt = 0;
            b0.req_ready = manual_ready;
        end else begin
            rcnt = rcnt + 1;
            b0.req_ready = (rcnt == int'(b0.req_0) + 3) || manual_ready;
        end
    end

    int          hi_lens[$];
    int          gaps[$];
    logic [31:0] args[$];
    int          hi = 0, lo = 0, unstable = 0;
    bit          seen = 1'b0;
    logic [31:0] cur = '0;
    always @(negedge clk) begin
        if (rst) begin
            hi = 0; lo = 0; seen = 1'b0;
        end else if (b0.req_valid) begin
            if (hi == 0) begin
                if (seen) gaps.push_back(lo);
                args.push_back(b0.req_0);
                cur = b0.req_0;
            end else if (b0.req_0 !== cur) begin
                unstable = unstable + 1;
            end
            hi = hi + 1;
        end else begin
            if (hi != 0) begin
                hi_lens.push_back(hi);
                seen = 1'b1;
                hi = 0;
                lo = 0;
            end
            lo = lo + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hi_lens.delete();
        gaps.delete();
        args.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((b0.busy || b0.req_valid) && n < bound) begin
            tick();
            n = n + 1;
        end
        chk("idle_bound", 32'(n < bound), 32'd1);
    endtask

    initial begin
        int hcnt;
        b0.cmd_valid = 1'b0; b0.cmd_cycles = '0;
        b1.cmd_valid = 1'b0; b1.cmd_cycles = '0; b1.req_ready = 1'b0;

        // Reset state
        do_reset();
        chk("rst_req_valid", 32'(b0.req_valid), 32'd0);
        chk("rst_req_0", b0.req_0, 32'd0);
        chk("rst_done", 32'(b0.done_count), 32'd0);
        chk("rst_terr", 32'(b0.timeout_err), 32'd0);
        chk("rst_cmd_ready", 32'(b0.cmd_ready), 32'd1);
        chk("rst_busy", 32'(b0.busy), 32'd0);
        chk("rst_terr1", 32'(b1.timeout_err), 32'd0);

        // Single request, arg 3 -> req_valid high 6 cycles
        b0.cmd_valid = 1'b1; b0.cmd_cycles = 32'd3;
        tick();
        b0.cmd_valid = 1'b0;
        chk("t1_not_yet", 32'(b0.req_valid), 32'd0);
        chk("t1_busy_q", 32'(b0.busy), 32'd1);
        tick();
        chk("t1_rise", 32'(b0.req_valid), 32'd1);
        chk("t1_arg", b0.req_0, 32'd3);
        repeat (5) tick();
        chk("t1_still_hi", 32'(b0.req_valid), 32'd1);
        chk("t1_arg_hold", b0.req_0, 32'd3);
        tick();
        chk("t1_fall", 32'(b0.req_valid), 32'd0);
        chk("t1_done", 32'(b0.done_count), 32'd1);
        chk("t1_busy_gap", 32'(b0.busy), 32'd1);
        tick();
        chk("t1_busy_end", 32'(b0.busy), 32'd0);
        chk("t1_nlen", 32'(hi_lens.size()), 32'd1);
        chk("t1_len", 32'(hi_lens[0]), 32'd6);

        // Zero argument -> 3 cycles
        do_reset();
        b0.cmd_valid = 1'b1; b0.cmd_cycles = 32'd0;
        tick();
        b0.cmd_valid = 1'b0;
        wait_idle(100);
        chk("t2_len", 32'(hi_lens[0]), 32'd3);
        chk("t2_done", 32'(b0.done_count), 32'd1);

        // Back-to-back 1, 2, 5
        do_reset();
        b0.cmd_valid = 1'b1;
        b0.cmd_cycles = 32'd1; tick();
        b0.cmd_cycles = 32'd2; tick();
        b0.cmd_cycles = 32'd5; tick();
        b0.cmd_valid = 1'b0;
        wait_idle(200);
        chk("t3_nreq", 32'(args.size()), 32'd3);
        chk("t3_arg0", args[0], 32'd1);
        chk("t3_arg1", args[1], 32'd2);
        chk("t3_arg2", args[2], 32'd5);
        chk("t3_len0", 32'(hi_lens[0]), 32'd4);
        chk("t3_len1", 32'(hi_lens[1]), 32'd5);
        chk("t3_len2", 32'(hi_lens[2]), 32'd8);
        chk("t3_gap0", 32'(gaps[0]), 32'd2);
        chk("t3_gap1", 32'(gaps[1]), 32'd2);
        chk("t3_done", 32'(b0.done_count), 32'd3);

        // FIFO full with a silent responder
        do_reset();
        resp_en = 1'b0;
        b0.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b0.cmd_cycles = 32'(10 + i);
            tick();
        end
        b0.cmd_cycles = 32'd15;
        chk("t4_full", 32'(b0.cmd_ready), 32'd0);
        chk("t4_issued", b0.req_0, 32'd10);
        tick();
        tick();
        chk("t4_held", 32'(b0.cmd_ready), 32'd0);
        chk("t4_hold_valid", 32'(b0.req_valid), 32'd1);
        manual_ready = 1'b1;
        tick();
        manual_ready = 1'b0;
        chk("t4_gap", 32'(b0.req_valid), 32'd0);
        chk("t4_done", 32'(b0.done_count), 32'd1);
        tick();
        chk("t4_idle_full", 32'(b0.cmd_ready), 32'd0);
        tick();
        chk("t4_space", 32'(b0.cmd_ready), 32'd1);
        chk("t4_next_arg", b0.req_0, 32'd11);
        tick();
        b0.cmd_valid = 1'b0;
        chk("t4_accepted", 32'(b0.cmd_ready), 32'd0);

        // Reset during ISSUE with two queued
        do_reset();
        b0.cmd_valid = 1'b1;
        b0.cmd_cycles = 32'd7; tick();
        b0.cmd_cycles = 32'd8; tick();
        b0.cmd_cycles = 32'd9; tick();
        b0.cmd_valid = 1'b0;
        chk("t5_issuing", 32'(b0.req_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_valid", 32'(b0.req_valid), 32'd0);
        chk("t5_busy", 32'(b0.busy), 32'd0);
        chk("t5_cmd_ready", 32'(b0.cmd_ready), 32'd1);
        chk("t5_done", 32'(b0.done_count), 32'd0);
        hi_lens.delete();
        resp_en = 1'b1;
        b0.cmd_valid = 1'b1; b0.cmd_cycles = 32'd2;
        tick();
        b0.cmd_valid = 1'b0;
        tick();
        chk("t5_reissue", 32'(b0.req_valid), 32'd1);
        chk("t5_reissue_arg", b0.req_0, 32'd2);
        wait_idle(100);
        chk("t5_done2", 32'(b0.done_count), 32'd1);
        chk("t5_len", 32'(hi_lens[0]), 32'd5);
        chk("stable_arg", 32'(unstable), 32'd0);

        // Watchdog on dut1, TIMEOUT=8, never answered
        do_reset();
        b1.cmd_valid = 1'b1; b1.cmd_cycles = 32'd4;
        tick();
        b1.cmd_valid = 1'b0;
        tick();
        chk("t6_rise", 32'(b1.req_valid), 32'd1);
        repeat (7) tick();
        chk("t6_8th", 32'(b1.req_valid), 32'd1);
        chk("t6_no_err_yet", 32'(b1.timeout_err), 32'd0);
        tick();
        chk("t6_fall", 32'(b1.req_valid), 32'd0);
        chk("t6_err", 32'(b1.timeout_err), 32'd1);
        chk("t6_done", 32'(b1.done_count), 32'd0);
        b1.cmd_valid = 1'b1; b1.cmd_cycles = 32'd1;
        tick();
        b1.cmd_valid = 1'b0;
        hcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (b1.req_valid) hcnt = hcnt + 1;
            tick();
        end
        chk("t6_halted", 32'(hcnt), 32'd0);
        chk("t6_busy_halt", 32'(b1.busy), 32'd1);
        do_reset();
        chk("t6_rst_clears", 32'(b1.timeout_err), 32'd0);
        chk("t6_rst_busy", 32'(b1.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
